// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for data_memory.
//   Request side : req_valid/req_ready handshake, req_write, req_size, req_unsigned,
//                  req_addr (byte address), req_wdata (right-aligned store data).
//   Response side: resp_valid pulse with resp_rdata (extended load data) and resp_err.
//   Memory side  : mem_read, mem_write, mem_address (word index), mem_write_data,
//                  mem_read_data (valid the cycle after mem_read rises).
//   clk rising edge; rst asynchronous active-low.
module load_store_unit #(
    parameter int W = 32,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N+1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    output logic [W-1:0] resp_rdata,
    output logic         resp_err,
    output logic         mem_read,
    output logic         mem_write,
    output logic [N-1:0] mem_address,
    output logic [W-1:0] mem_write_data,
    input  logic [W-1:0] mem_read_data
);
    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_t;
    state_t state_q, state_d;
    logic [N+1:0] addr_q, addr_d;
    logic [1:0]   size_q, size_d;
    logic         write_q, write_d, uns_q, uns_d, err_q, err_d;
    logic [W-1:0] rdata_q, rdata_d, mwdata_q, mwdata_d;
    logic         misaligned;
    logic [7:0]   byte_lane;
    logic [15:0]  half_lane;
    logic [3:0]   be;
    logic [31:0]  rep, ext, merged;

    always_comb begin
        misaligned = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                     (req_size == 2'b10 & |req_addr[1:0]);
        byte_lane  = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        half_lane  = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        ext        = size_q == 2'b00 ? {{24{byte_lane[7] & ~uns_q}}, byte_lane} :
                     size_q == 2'b01 ? {{16{half_lane[15] & ~uns_q}}, half_lane} : mem_read_data;
        be         = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                     size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // Store data is still parked in mwdata_q until the merge overwrites it.
        rep        = size_q == 2'b00 ? {4{mwdata_q[7:0]}} :
                     size_q == 2'b01 ? {2{mwdata_q[15:0]}} : mwdata_q;
        for (int k = 0; k < 4; k++)
            merged[8*k +: 8] = be[k] ? rep[8*k +: 8] : mem_read_data[8*k +: 8];
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        uns_d    = uns_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        mwdata_d = mwdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d   = req_addr;
                size_d   = req_size;
                write_d  = req_write;
                uns_d    = req_unsigned;
                err_d    = misaligned;
                rdata_d  = '0;
                mwdata_d = req_wdata;
                state_d  = misaligned ? RESP : (req_write && req_size == 2'b10) ? WRITE : READ;
            end
            READ:  state_d = CAPT;
            CAPT:  begin
                mwdata_d = write_q ? merged : mwdata_q;
                rdata_d  = write_q ? rdata_q : ext;
                state_d  = write_q ? WRITE : RESP;
            end
            WRITE: state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            uns_q    <= uns_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            mwdata_q <= mwdata_d;
        end
    end

    // Strobes decode from state so an asynchronous reset drops them at once.
    assign req_ready      = state_q == IDLE;
    assign resp_valid     = state_q == RESP;
    assign resp_err       = resp_valid & err_q;
    assign mem_read       = state_q == READ || state_q == CAPT;
    assign mem_write      = state_q == WRITE;
    assign mem_address    = addr_q[N+1:2];
    assign mem_write_data = mwdata_q;
    assign resp_rdata     = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a synchronous-read memory model.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_write_data, mem_read_data;
    logic [4:0]  mem_address;
    logic [31:0] mem [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_a = '0;
    logic [31:0] pre_d = '0;
    int          n_chk = 0, n_fail = 0, n_wr = 0, n_rd = 0, n_resp = 0, n_acc = 0, n_bad = 0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;

    always #5 clk = ~clk;

    load_store_unit #(.W(32), .N(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        if (mem_write) mem[mem_address] <= mem_write_data;
        if (mem_read) mem_read_data <= mem[mem_address];
        if (rst && req_valid && req_ready) n_acc++;
    end

    always @(negedge clk) begin
        if (mem_write) begin
            n_wr++;
            wa = mem_address;
            wd = mem_write_data;
        end
        if (mem_read) n_rd++;
        if (resp_valid) n_resp++;
        if ((mem_read && mem_write) || ((req_ready || resp_valid) && (mem_read || mem_write))) n_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic go(input string tag, input logic wr, input logic [1:0] sz, input logic un,
                      input logic [6:0] a, input logic [31:0] wdt, input int el,
                      input logic [31:0] erd, input logic eer, input int enw, input int enr);
        int lat, w0, r0;
        w0 = n_wr;
        r0 = n_rd;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wdt;
        wait_ready();
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, lat, el);
        check({tag, "_rdata"}, resp_rdata, erd);
        check({tag, "_err"}, 32'(resp_err), 32'(eer));
        check({tag, "_nwrites"}, n_wr - w0, enw);
        check({tag, "_nreads"}, n_rd - r0, enr);
    endtask

    logic [6:0]  ba [3] = '{7'h00, 7'h7C, 7'h7F};
    logic [1:0]  bs [3] = '{2'b10, 2'b10, 2'b00};
    logic [31:0] bd [3] = '{32'hCAFEF00D, 32'h12345678, 32'h0000009A};

    initial begin
        int acc0, r0, w0;
        #12;
        check("rst_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_err", 32'(resp_err), 0);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_mem_address", 32'(mem_address), 0);
        check("rst_mem_wdata", mem_write_data, 0);
        @(negedge clk) rst = 1'b1;

        go("st_word", 1, 2'b10, 0, 7'h08, 32'hDEADBEEF, 2, 0, 0, 1, 0);
        check("st_word_addr", 32'(wa), 2);
        check("st_word_data", wd, 32'hDEADBEEF);
        go("ld_word", 0, 2'b10, 0, 7'h08, 0, 3, 32'hDEADBEEF, 0, 0, 2);

        poke(2, 32'h11223344);
        go("st_byte", 1, 2'b00, 0, 7'h0A, 32'h000000AB, 4, 0, 0, 1, 2);
        check("st_byte_data", wd, 32'h11AB3344);
        check("st_byte_mem", mem[2], 32'h11AB3344);

        poke(3, 32'h80FF7F01);
        go("ld_sb_e", 0, 2'b00, 0, 7'h0E, 0, 3, 32'hFFFFFFFF, 0, 0, 2);
        go("ld_ub_e", 0, 2'b00, 1, 7'h0E, 0, 3, 32'h000000FF, 0, 0, 2);
        go("ld_sh_e", 0, 2'b01, 0, 7'h0E, 0, 3, 32'hFFFF80FF, 0, 0, 2);
        go("ld_sb_c", 0, 2'b00, 0, 7'h0C, 0, 3, 32'h00000001, 0, 0, 2);
        go("ld_uh_c", 0, 2'b01, 1, 7'h0C, 0, 3, 32'h00007F01, 0, 0, 2);
        go("ld_sb_d", 0, 2'b00, 0, 7'h0D, 0, 3, 32'h0000007F, 0, 0, 2);
        go("ld_w_c", 0, 2'b10, 1, 7'h0C, 0, 3, 32'h80FF7F01, 0, 0, 2);
        go("st_half", 1, 2'b01, 0, 7'h0E, 32'hFFFF1234, 4, 0, 0, 1, 2);
        check("st_half_mem", mem[3], 32'h12347F01);

        go("mis_half", 0, 2'b01, 0, 7'h05, 0, 1, 0, 1, 0, 0);
        go("mis_word", 1, 2'b10, 0, 7'h06, 32'h55555555, 1, 0, 1, 0, 0);
        go("mis_size", 0, 2'b11, 0, 7'h00, 0, 1, 0, 1, 0, 0);

        acc0 = n_acc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b1; req_unsigned = 1'b0;
            req_addr = ba[i]; req_size = bs[i]; req_wdata = bd[i];
            wait_ready();
            @(posedge clk);
            #1 check("b2b_ready_low", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        wait_ready();
        check("b2b_accepts", n_acc - acc0, 3);
        check("b2b_mem0", mem[0], 32'hCAFEF00D);
        check("b2b_mem31", mem[31], 32'h9A345678);

        poke(5, 32'h55667788);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 7'h15; req_wdata = 32'hEE;
        wait_ready();
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("rmo_in_write", 32'(mem_write), 1);
        r0 = n_resp;
        w0 = n_wr;
        #2 rst = 1'b0;
        #1 check("rmo_write_drop", 32'(mem_write), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("rmo_ready", 32'(req_ready), 1);
        check("rmo_no_resp", n_resp - r0, 0);
        check("rmo_no_write", n_wr - w0, 0);
        check("rmo_mem5", mem[5], 32'h55667788);
        go("rmo_load", 0, 2'b10, 0, 7'h14, 0, 3, 32'h55667788, 0, 0, 2);

        check("exclusivity", n_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
